mag_sqrt_seq: RTL and testbench

Sequential integer square-root stage for the magnitude calculator datapath. It takes the 17-bit sum of squares x²+y² produced by the squaring/adder stage and returns the 9-bit root, which drives the `uo_out` magnitude. The algorithm is digit-by-digit, one root bit per clock. Valid/ready handshakes on both sides let it sit between the sum-of-squares producer and the output register.

---
 rtl/mag_pkg.sv | 14 +
 rtl/mag_sqrt_step.sv | 25 ++
 rtl/mag_sqrt_seq.sv | 101 ++++++++++
 tb/tb_mag_sqrt_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mag_pkg.sv
// Shared constants and types for the magnitude-calculator square-root stage.
package mag_pkg;

    localparam int RAD_W  = 17;
    localparam int ROOT_W = (RAD_W + 1) / 2;
    localparam int CNT_W  = $clog2(ROOT_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mag_sqrt_state_t;

endpackage

// File: rtl/mag_sqrt_step.sv
// One iteration of the digit-by-digit square root: brings in two radicand bits,
// tries the next root bit and updates partial root and remainder (combinational).
module mag_sqrt_step #(
    parameter int ROOT_W = mag_pkg::ROOT_W
) (
    input  logic [ROOT_W-1:0] root_in,
    input  logic [ROOT_W+1:0] rem_in,
    input  logic [1:0]        bits,
    output logic [ROOT_W-1:0] root_next,
    output logic [ROOT_W+1:0] rem_next
);

    logic [ROOT_W+1:0] rem_sh;
    logic [ROOT_W+1:0] trial;
    logic              ge;

    // The running remainder never exceeds 2*root, so the two MSBs dropped by
    // the shift are always zero and ROOT_W+2 bits hold the shifted value.
    assign rem_sh    = {rem_in[ROOT_W-1:0], bits};
    assign trial     = {root_in, 2'b01};
    assign ge        = (rem_sh >= trial);
    assign root_next = {root_in[ROOT_W-2:0], ge};
    assign rem_next  = ge ? (rem_sh - trial) : rem_sh;

endmodule

// File: rtl/mag_sqrt_seq.sv
// Sequential integer square root, one root bit per enabled clock, with valid/ready
// handshakes. Define MAG_SQRT_ROUND_EN to round the root to nearest instead of floor.
module mag_sqrt_seq #(
    parameter int RAD_W  = mag_pkg::RAD_W,
    parameter int ROOT_W = (RAD_W + 1) / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RAD_W-1:0]  radicand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem
);

    localparam int CNT_W = $clog2(ROOT_W);
    localparam int SR_W  = 2 * ROOT_W;

    mag_pkg::mag_sqrt_state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   rad_sr;
    logic [ROOT_W-1:0] part_root;
    logic [ROOT_W+1:0] part_rem;
    logic [ROOT_W-1:0] root_q;
    logic [ROOT_W:0]   rem_q;

    logic [ROOT_W-1:0] step_root;
    logic [ROOT_W+1:0] step_rem;
    logic [ROOT_W-1:0] final_root;
    logic              accept;
    logic              last_step;

    mag_sqrt_step #(.ROOT_W(ROOT_W)) u_step (
        .root_in   (part_root),
        .rem_in    (part_rem),
        .bits      (rad_sr[SR_W-1 -: 2]),
        .root_next (step_root),
        .rem_next  (step_rem)
    );

`ifdef MAG_SQRT_ROUND_EN
    logic round_up;
    assign round_up   = (step_rem > {2'b00, step_root});
    assign final_root = step_root + {{(ROOT_W-1){1'b0}}, round_up};
`else
    assign final_root = step_root;
`endif

    assign in_ready  = (state == mag_pkg::IDLE) && ena;
    assign out_valid = (state == mag_pkg::DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state == mag_pkg::CALC) && ena && (cnt == '0);
    assign root      = root_q;
    assign rem       = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= mag_pkg::IDLE;
        else        state <= state_next;
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            mag_pkg::IDLE: if (accept)                       state_next = mag_pkg::CALC;
            mag_pkg::CALC: if (last_step)                    state_next = mag_pkg::DONE;
            mag_pkg::DONE: if (ena && out_ready)             state_next = mag_pkg::IDLE;
            default:                                         state_next = mag_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rad_sr    <= '0;
            part_root <= '0;
            part_rem  <= '0;
            root_q    <= '0;
            rem_q     <= '0;
        end else if (accept) begin
            cnt       <= CNT_W'(ROOT_W - 1);
            rad_sr    <= SR_W'(radicand);
            part_root <= '0;
            part_rem  <= '0;
        end else if (ena && (state == mag_pkg::CALC)) begin
            cnt       <= cnt - 1'b1;
            rad_sr    <= {rad_sr[SR_W-3:0], 2'b00};
            part_root <= step_root;
            part_rem  <= step_rem;
            if (cnt == '0) begin
                root_q <= final_root;
                rem_q  <= step_rem[ROOT_W:0];
            end
        end
    end

endmodule

// File: tb/tb_mag_sqrt_seq.sv
// Directed self-checking bench for mag_sqrt_seq; expectations follow MAG_SQRT_ROUND_EN.
module tb_mag_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] radicand;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  root;
    logic [9:0]  rem;

    int total = 0;
    int bad   = 0;

`ifdef MAG_SQRT_ROUND_EN
    localparam int R130050 = 361;
    localparam int R3      = 2;
`else
    localparam int R130050 = 360;
    localparam int R3      = 1;
`endif

    mag_sqrt_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .radicand  (radicand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a radicand and let the next edge accept it.
    task automatic send(input string tag, input logic [16:0] v);
        radicand = v;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid (bounded), then check latency and result.
    task automatic wait_done(input string tag, input int start, input int exp_lat,
                             input int exp_root, input int exp_rem);
        int   lat;
        logic rdy_seen;
        lat      = start;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
            rdy_seen |= in_ready;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_in_ready_busy"}, rdy_seen, 0);
        check({tag, "_root"}, root, exp_root);
        check({tag, "_rem"}, rem, exp_rem);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        radicand  = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_root", root, 0);
        check("rst_rem", rem, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic transaction
        send("r100", 17'd100);
        wait_done("r100", 0, 9, 10, 0);
        consume("r100");

        // Back-to-back with upstream holding valid
        out_ready = 1'b1;
        radicand  = 17'd200;
        in_valid  = 1'b1;
        tick();
        radicand  = 17'd125;
        wait_done("r200", 0, 9, 14, 4);
        tick();
        check("b2b_idle_valid", out_valid, 0);
        check("b2b_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_accepted", in_ready, 0);
        wait_done("r125", 0, 9, 11, 4);
        consume("r125");

        // Boundaries
        send("r130050", 17'd130050);
        wait_done("r130050", 0, 9, R130050, 450);
        consume("r130050");
        send("r3", 17'd3);
        wait_done("r3", 0, 9, R3, 2);
        consume("r3");
        send("r0", 17'd0);
        wait_done("r0", 0, 9, 0, 0);
        consume("r0");

        // Backpressure: hold in DONE, offer a new radicand that must be ignored
        send("r64", 17'd64);
        wait_done("r64", 0, 9, 8, 0);
        radicand = 17'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_root", root, 8);
            check("bp_rem", rem, 0);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume("bp");
        check("bp_idle", in_ready, 1);
        check("bp_root_held", root, 8);

        // ena low for 3 cycles mid-CALC
        send("r144", 17'd144);
        tick(); tick(); tick();
        ena = 1'b0;
        check("ena_in_ready", in_ready, 0);
        tick(); tick(); tick();
        check("ena_frozen_valid", out_valid, 0);
        ena = 1'b1;
        wait_done("r144", 6, 12, 12, 0);
        consume("r144");

        // Asynchronous reset mid-CALC
        send("r_abort", 17'd130050);
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_root", root, 0);
        check("arst_rem", rem, 0);
        check("arst_idle", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_no_pulse", out_valid, 0);
        send("r49", 17'd49);
        wait_done("r49", 0, 9, 7, 0);
        consume("r49");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
